// File: rtl/t_ff_mod_counter.sv
// Modulo-MOD up/down counter built from T flip-flops; each bit toggles on t[i] = q[i] ^ next[i].
// Optional load path (ports load/din) enabled by defining TFF_COUNTER_LOAD_EN.
module t_ff_mod_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
`ifdef TFF_COUNTER_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] din,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] next_val;
  logic [WIDTH-1:0] t;
  logic             wrap_q, wrap_d;
  logic             at_max, at_zero;
  logic             load_act;
  logic [WIDTH-1:0] load_val;

`ifdef TFF_COUNTER_LOAD_EN
  // Out-of-range load data saturates to the top count so q never leaves 0..MOD-1.
  assign load_act = load;
  assign load_val = (32'(din) >= MOD) ? MaxVal : din;
`else
  assign load_act = 1'b0;
  assign load_val = '0;
`endif

  assign at_max  = (q_q == MaxVal);
  assign at_zero = (q_q == '0);

  always_comb begin
    next_val = q_q;
    wrap_d   = 1'b0;
    if (load_act) begin
      next_val = load_val;
    end else if (en) begin
      if (up) begin
        next_val = at_max ? '0 : q_q + WIDTH'(1);
        wrap_d   = at_max;
      end else begin
        next_val = at_zero ? MaxVal : q_q - WIDTH'(1);
        wrap_d   = at_zero;
      end
    end
  end

  assign t = q_q ^ next_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_q ^ t;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign qb   = ~q_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_t_ff_mod_counter.sv
// Self-checking bench for t_ff_mod_counter: directed scenarios plus randomized traffic vs a
// modular-arithmetic reference model. Exercises the load path when TFF_COUNTER_LOAD_EN is defined.
module tb_t_ff_mod_counter;

`ifdef TFF_COUNTER_LOAD_EN
  localparam bit LoadOn = 1'b1;
`else
  localparam bit LoadOn = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: WIDTH=4, MOD=10
  logic       rst = 1'b1, en = 1'b0, up = 1'b1;
  logic       load = 1'b0;
  logic [3:0] din = 4'd0;
  logic [3:0] q, qb;
  logic       wrap;

  // DUT B: WIDTH=3, MOD=8
  logic       rst8 = 1'b1, en8 = 1'b0, up8 = 1'b1;
  logic       load8 = 1'b0;
  logic [2:0] din8 = 3'd0;
  logic [2:0] q8, qb8;
  logic       wrap8;

  t_ff_mod_counter #(.WIDTH(4), .MOD(10)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .up   (up),
`ifdef TFF_COUNTER_LOAD_EN
    .load (load),
    .din  (din),
`endif
    .q    (q),
    .qb   (qb),
    .wrap (wrap)
  );

  t_ff_mod_counter #(.WIDTH(3), .MOD(8)) dut8 (
    .clk  (clk),
    .rst  (rst8),
    .en   (en8),
    .up   (up8),
`ifdef TFF_COUNTER_LOAD_EN
    .load (load8),
    .din  (din8),
`endif
    .q    (q8),
    .qb   (qb8),
    .wrap (wrap8)
  );

  // Reference state: the count as an integer and the expected wrap flag
  int mq = 0, mw = 0;
  int m8q = 0, m8w = 0;
  bit armed = 1'b0;

  task automatic tick(input logic r, input logic e, input logic u, input logic l,
                      input logic [3:0] d);
    rst = r; en = e; up = u; load = l; din = d;
    @(posedge clk);
    #1;
    if (r) begin
      mq = 0; mw = 0;
    end else if (l && LoadOn) begin
      mq = (int'(d) >= 10) ? 9 : int'(d);
      mw = 0;
    end else if (e) begin
      if (u) begin
        mw = (mq == 9) ? 1 : 0;
        mq = (mq + 1) % 10;
      end else begin
        mw = (mq == 0) ? 1 : 0;
        mq = (mq + 10 - 1) % 10;
      end
    end else begin
      mw = 0;
    end
  endtask

  task automatic tick8(input logic r, input logic e, input logic u);
    rst8 = r; en8 = e; up8 = u;
    @(posedge clk);
    #1;
    if (r) begin
      m8q = 0; m8w = 0;
    end else if (e) begin
      m8w = (u ? (m8q == 7) : (m8q == 0)) ? 1 : 0;
      m8q = u ? (m8q + 1) % 8 : (m8q + 7) % 8;
    end else begin
      m8w = 0;
    end
  endtask

  // Range invariant on every cycle once reset has been applied
  always @(negedge clk) begin
    if (armed) begin
      checks++;
      if (q >= 4'd10) begin
        errors++;
        $display("FAIL range: q=%0d, required < 10", q);
      end
    end
  end

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    armed = 1'b1;
    checks++;
    if (q !== 4'd0) begin errors++; $display("FAIL reset_q: got %0d required 0", q); end
    checks++;
    if (qb !== 4'hF) begin errors++; $display("FAIL reset_qb: got %h required F", qb); end
    checks++;
    if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b required 0", wrap); end
  endtask

  task automatic test_up_count();
    int pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      checks++;
      if (q !== 4'(mq)) begin
        errors++; $display("FAIL up_q step %0d: got %0d required %0d", i, q, mq);
      end
      checks++;
      if (wrap !== mw[0]) begin
        errors++; $display("FAIL up_wrap step %0d: got %b required %0d", i, wrap, mw);
      end
      checks++;
      if (qb !== ~q) begin
        errors++; $display("FAIL up_qb step %0d: got %h required %h", i, qb, ~q);
      end
      if (wrap === 1'b1) pulses++;
    end
    checks++;
    if (q !== 4'd2 || pulses != 1) begin
      errors++; $display("FAIL up_end: q=%0d pulses=%0d, required q=2 pulses=1", q, pulses);
    end
  endtask

  task automatic test_down_dir_change();
    logic [3:0] exp_seq [4];
    logic       exp_wr  [4];
    exp_seq[0] = 4'd1; exp_seq[1] = 4'd0; exp_seq[2] = 4'd9; exp_seq[3] = 4'd0;
    exp_wr[0] = 1'b0;  exp_wr[1] = 1'b0;  exp_wr[2] = 1'b1;  exp_wr[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, (i == 3), 1'b0, 4'd0);
      checks++;
      if (q !== exp_seq[i] || q !== 4'(mq)) begin
        errors++; $display("FAIL down_q step %0d: got %0d required %0d", i, q, exp_seq[i]);
      end
      checks++;
      if (wrap !== exp_wr[i]) begin
        errors++; $display("FAIL down_wrap step %0d: got %b required %b", i, wrap, exp_wr[i]);
      end
    end
  endtask

  task automatic test_hold_and_reset();
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, i[0], 1'b0, 4'd0);
      checks++;
      if (q !== 4'd5 || wrap !== 1'b0) begin
        errors++; $display("FAIL hold step %0d: q=%0d wrap=%b required q=5 wrap=0", i, q, wrap);
      end
    end
    tick(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    checks++;
    if (q !== 4'd0 || wrap !== 1'b0) begin
      errors++; $display("FAIL mid_reset: q=%0d wrap=%b required q=0 wrap=0", q, wrap);
    end
  endtask

  task automatic test_pow2();
    int pulses = 0;
    tick8(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      tick8(1'b0, 1'b1, 1'b1);
      checks++;
      if (q8 !== 3'(m8q) || wrap8 !== m8w[0]) begin
        errors++;
        $display("FAIL pow2 step %0d: q=%0d wrap=%b required q=%0d wrap=%0d",
                 i, q8, wrap8, m8q, m8w);
      end
      if (wrap8 === 1'b1) pulses++;
    end
    checks++;
    if (q8 !== 3'd1 || pulses != 1) begin
      errors++; $display("FAIL pow2_end: q=%0d pulses=%0d required q=1 pulses=1", q8, pulses);
    end
    for (int i = 0; i < 3; i++) begin
      tick8(1'b0, 1'b1, 1'b0);
      checks++;
      if (q8 !== 3'(m8q) || wrap8 !== m8w[0] || qb8 !== ~q8) begin
        errors++;
        $display("FAIL pow2_down step %0d: q=%0d wrap=%b required q=%0d wrap=%0d",
                 i, q8, wrap8, m8q, m8w);
      end
    end
  endtask

  task automatic test_load();
    tick(1'b0, 1'b1, 1'b1, 1'b1, 4'd7);
    checks++;
    if (q !== 4'd7 || wrap !== 1'b0) begin
      errors++; $display("FAIL load7: q=%0d wrap=%b required q=7 wrap=0", q, wrap);
    end
    tick(1'b0, 1'b1, 1'b1, 1'b1, 4'd12);
    checks++;
    if (q !== 4'd9 || wrap !== 1'b0) begin
      errors++; $display("FAIL load12: q=%0d wrap=%b required q=9 wrap=0", q, wrap);
    end
    // Load while sitting at the top count must not flag a wrap
    tick(1'b0, 1'b1, 1'b1, 1'b1, 4'd3);
    checks++;
    if (q !== 4'd3 || wrap !== 1'b0) begin
      errors++; $display("FAIL load_at_max: q=%0d wrap=%b required q=3 wrap=0", q, wrap);
    end
    tick(1'b1, 1'b1, 1'b1, 1'b1, 4'd6);
    checks++;
    if (q !== 4'd0 || wrap !== 1'b0) begin
      errors++; $display("FAIL rst_over_load: q=%0d wrap=%b required q=0 wrap=0", q, wrap);
    end
  endtask

  task automatic test_random();
    logic r, e, u, l;
    logic [3:0] d;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 19) == 0);
      e = ($urandom_range(0, 3) != 0);
      u = $urandom_range(0, 1) == 1;
      l = LoadOn && ($urandom_range(0, 9) == 0);
      d = 4'($urandom_range(0, 15));
      tick(r, e, u, l, d);
      checks++;
      if (q !== 4'(mq) || wrap !== mw[0] || qb !== ~4'(mq)) begin
        errors++;
        $display("FAIL random step %0d: q=%0d qb=%h wrap=%b required q=%0d wrap=%0d",
                 i, q, qb, wrap, mq, mw);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_dir_change();
    test_hold_and_reset();
    test_pow2();
`ifdef TFF_COUNTER_LOAD_EN
    test_load();
`endif
    test_random();
    armed = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
